// File: rtl/mem_req_sequencer.sv
// -----------------------------------------------------------------------------
// mem_req_sequencer
//
// Command front-end for the dual-port coded RAM (dp_mem_merged). Client
// requests are queued in a small FIFO. Bursts are expanded into single-beat
// accesses, one beat per cycle. Read data comes back as tagged one-cycle
// responses.
//
// Optional feature macro: SEQ_WR_VERIFY_EN
//   When defined, every write beat is followed by a read-back of the same
//   address. The returned word is compared with the expected coded word.
//   A mismatch sets the sticky verify_err flag.
//   When undefined, verify_err is tied to 0.
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   req_valid/req_ready         request handshake; req_ready == !full
//   req_wr, req_burst           op type; a burst is BURST_LEN beats
//   req_addr, req_wdata         start address and beat-0 write data
//   mem_enb/wr/rd/burst         memory command pins (all registered)
//   mem_w_addr/r_addr/w_data    memory address/data pins (registered)
//   mem_r_data                  memory read data (valid the cycle after a read)
//   rsp_valid/data/addr         read response; arrives 2 cycles after the read beat
//   busy                        sequencer active, FIFO non-empty or read pending
//   verify_err                  sticky write-verify mismatch
// -----------------------------------------------------------------------------
module mem_req_sequencer #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_enb,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic              mem_burst,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              busy,
  output logic              verify_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BC_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int ENT_W = 2 + ADDR_W + DATA_W;

`ifdef SEQ_WR_VERIFY_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_VERIFY = 2'd2} state_t;

  localparam int POP_W = $clog2(DATA_W + 1);

  // Word the memory is expected to hold: inverted when more than half the bits are set.
  function automatic logic [DATA_W-1:0] inv_code(input logic [DATA_W-1:0] d);
    logic [POP_W-1:0] ones;
    ones = {POP_W{1'b0}};
    for (int k = 0; k < DATA_W; k++) begin
      ones = ones + POP_W'(d[k]);
    end
    return (ones > POP_W'(DATA_W / 2)) ? ~d : d;
  endfunction
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1} state_t;
`endif

  state_t state_r, state_nxt_s;

  logic [ENT_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [BC_W-1:0]  beat_cnt_r;

  logic              full_s, empty_s, push_s, pop_s, load_s, verify_due_s, last_beat_s;
  logic              head_wr_s, head_burst_s;
  logic [ADDR_W-1:0] head_addr_s, beat_addr_s;
  logic [DATA_W-1:0] head_wdata_s, beat_data_s;
  logic [2:0]        beat_low_s;

  logic              enb_nxt_s, wr_nxt_s, rd_nxt_s;
  logic [ADDR_W-1:0] w_addr_nxt_s, r_addr_nxt_s;
  logic [DATA_W-1:0] w_data_nxt_s;

  logic              mem_enb_r, mem_wr_r, mem_rd_r;
  logic [ADDR_W-1:0] mem_w_addr_r, mem_r_addr_r;
  logic [DATA_W-1:0] mem_w_data_r;

  logic              rd_pend_r;
  logic [ADDR_W-1:0] pend_addr_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic [ADDR_W-1:0] rsp_addr_r;

  assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign push_s  = req_valid & ~full_s;

  assign {head_wr_s, head_burst_s, head_addr_s, head_wdata_s} = fifo_mem_r[rd_ptr_r];

  assign last_beat_s = head_burst_s ? (beat_cnt_r == BC_W'(BURST_LEN - 1)) : 1'b1;

  // Beats wrap inside the 8-entry row of the selected bank; bit 3 is always cleared.
  assign beat_low_s  = head_addr_s[2:0] + 3'(beat_cnt_r);
  assign beat_addr_s = {head_addr_s[ADDR_W-1], {(ADDR_W-4){1'b0}}, beat_low_s};
  assign beat_data_s = head_wdata_s + DATA_W'(beat_cnt_r);

`ifdef SEQ_WR_VERIFY_EN
  // A write beat on the pins now forces a read-back next cycle.
  assign verify_due_s = (state_r == ST_ISSUE) & mem_wr_r;
`else
  assign verify_due_s = 1'b0;
`endif

  // A beat is loaded into the pin registers whenever one is queued and no read-back is owed.
  assign load_s = ~empty_s & ~verify_due_s;
  assign pop_s  = load_s & last_beat_s;

  // Request storage; contents are qualified by the pointers, so they need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {req_wr, req_burst, req_addr, req_wdata};
    end
  end

  // FIFO pointers, occupancy and beat counter of the head request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      beat_cnt_r <= {BC_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (load_s) begin
        beat_cnt_r <= last_beat_s ? {BC_W{1'b0}} : beat_cnt_r + BC_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; the state names what the pin registers carry next cycle.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (load_s) state_nxt_s = ST_ISSUE;
        else        state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
`ifdef SEQ_WR_VERIFY_EN
        if (verify_due_s) state_nxt_s = ST_VERIFY;
        else if (load_s)  state_nxt_s = ST_ISSUE;
        else              state_nxt_s = ST_IDLE;
`else
        if (load_s) state_nxt_s = ST_ISSUE;
        else        state_nxt_s = ST_IDLE;
`endif
      end
`ifdef SEQ_WR_VERIFY_EN
      ST_VERIFY: begin
        if (load_s) state_nxt_s = ST_ISSUE;
        else        state_nxt_s = ST_IDLE;
      end
`endif
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next value of the memory command pins.
  always_comb begin
    enb_nxt_s    = 1'b0;
    wr_nxt_s     = 1'b0;
    rd_nxt_s     = 1'b0;
    w_addr_nxt_s = {ADDR_W{1'b0}};
    r_addr_nxt_s = {ADDR_W{1'b0}};
    w_data_nxt_s = {DATA_W{1'b0}};
    if (verify_due_s) begin
      // Read back the address just written; write data is held but ignored.
      enb_nxt_s    = 1'b1;
      rd_nxt_s     = 1'b1;
      w_addr_nxt_s = mem_w_addr_r;
      r_addr_nxt_s = mem_w_addr_r;
      w_data_nxt_s = mem_w_data_r;
    end else if (load_s) begin
      enb_nxt_s    = 1'b1;
      wr_nxt_s     = head_wr_s;
      rd_nxt_s     = ~head_wr_s;
      w_addr_nxt_s = beat_addr_s;
      r_addr_nxt_s = beat_addr_s;
      w_data_nxt_s = head_wr_s ? beat_data_s : {DATA_W{1'b0}};
    end else begin
      enb_nxt_s = 1'b0;
    end
  end

  // Memory pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_enb_r    <= 1'b0;
      mem_wr_r     <= 1'b0;
      mem_rd_r     <= 1'b0;
      mem_w_addr_r <= {ADDR_W{1'b0}};
      mem_r_addr_r <= {ADDR_W{1'b0}};
      mem_w_data_r <= {DATA_W{1'b0}};
    end else begin
      mem_enb_r    <= enb_nxt_s;
      mem_wr_r     <= wr_nxt_s;
      mem_rd_r     <= rd_nxt_s;
      mem_w_addr_r <= w_addr_nxt_s;
      mem_r_addr_r <= r_addr_nxt_s;
      mem_w_data_r <= w_data_nxt_s;
    end
  end

  // Read tracking: the memory's r_data is valid the cycle after a read beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_r   <= 1'b0;
      pend_addr_r <= {ADDR_W{1'b0}};
    end else begin
      rd_pend_r   <= mem_enb_r & mem_rd_r;
      pend_addr_r <= mem_r_addr_r;
    end
  end

`ifdef SEQ_WR_VERIFY_EN
  logic              pend_verify_r;
  logic [DATA_W-1:0] vexp_r;
  logic              verify_err_r;

  // Remember whether the pending read is a read-back and what it should return.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_verify_r <= 1'b0;
      vexp_r        <= {DATA_W{1'b0}};
    end else begin
      pend_verify_r <= (state_r == ST_VERIFY);
      vexp_r        <= inv_code(mem_w_data_r);
    end
  end

  // Sticky read-back mismatch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      verify_err_r <= 1'b0;
    end else begin
      verify_err_r <= verify_err_r | (rd_pend_r & pend_verify_r & (mem_r_data != vexp_r));
    end
  end

  assign verify_err = verify_err_r;
`else
  logic pend_verify_r;

  assign pend_verify_r = 1'b0;
  assign verify_err    = 1'b0;
`endif

  // Response registers; read-backs never produce a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      rsp_valid_r <= rd_pend_r & ~pend_verify_r;
      if (rd_pend_r & ~pend_verify_r) begin
        rsp_data_r <= mem_r_data;
        rsp_addr_r <= pend_addr_r;
      end
    end
  end

  assign req_ready  = ~full_s;
  assign mem_enb    = mem_enb_r;
  assign mem_wr     = mem_wr_r;
  assign mem_rd     = mem_rd_r;
  assign mem_burst  = 1'b0;
  assign mem_w_addr = mem_w_addr_r;
  assign mem_r_addr = mem_r_addr_r;
  assign mem_w_data = mem_w_data_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_addr   = rsp_addr_r;
  assign busy       = (state_r != ST_IDLE) | ~empty_s | rd_pend_r;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mem_req_sequencer.
// The bench keeps a behavioural model: a queue of expected memory beats with
// their earliest issue cycle, a queue of expected responses with their due
// cycle, and a shadow copy of the coded memory contents. A simple coded-RAM
// model drives mem_r_data.
// -----------------------------------------------------------------------------
module tb_mem_req_sequencer;

`ifdef SEQ_WR_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif
  localparam int INF = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_wr = 1'b0;
  logic       req_burst = 1'b0;
  logic [4:0] req_addr = 5'h00;
  logic [7:0] req_wdata = 8'h00;
  logic [7:0] mem_r_data = 8'h00;
  logic       req_ready, mem_enb, mem_wr, mem_rd, mem_burst, rsp_valid, busy, verify_err;
  logic [4:0] mem_w_addr, mem_r_addr, rsp_addr;
  logic [7:0] mem_w_data, rsp_data;

  mem_req_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_burst(req_burst),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_enb(mem_enb), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_burst(mem_burst),
    .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .busy(busy), .verify_err(verify_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Coded RAM behaviour: words with more than 4 ones are stored inverted.
  // flip_en plants a stuck bit 0 for data 0x13 written to address 0x01.
  bit flip_en = 1'b0;

  function automatic logic [7:0] store_code(input logic [7:0] d);
    return ($countones(d) > 4) ? ~d : d;
  endfunction

  function automatic logic [7:0] stored_word(input logic [4:0] a, input logic [7:0] d);
    return store_code(d) ^ ((flip_en && a == 5'h01 && d == 8'h13) ? 8'h01 : 8'h00);
  endfunction

  logic [7:0] env_mem [32];

  // Memory environment driven by the DUT pins.
  always @(posedge clk) begin
    if (mem_enb && mem_wr) env_mem[mem_w_addr] <= stored_word(mem_w_addr, mem_w_data);
    if (mem_enb && mem_rd) mem_r_data <= env_mem[mem_r_addr];
  end

  // ---------------- reference model ----------------
  typedef struct { bit wr; logic [4:0] addr; logic [7:0] data; int acc; bit last; } beat_t;
  typedef struct { int due; logic [4:0] addr; logic [7:0] data; } rsp_t;

  beat_t      beats[$];
  rsp_t       rsps[$];
  logic [7:0] shadow [32];
  int         cyc = 0;
  int         fifo_cnt_m = 0;
  int         err_at = INF;
  bit         vdue = 1'b0;
  logic [4:0] vaddr;
  logic [7:0] vdata;
  bit         rd_prev = 1'b0;
  bit         mon_en = 1'b0;
  logic [7:0] last_rsp_data = 8'h00;
  logic [4:0] last_rsp_addr = 5'h00;

  // Accepted requests become expected beats; reset empties the model.
  always @(posedge clk) begin
    if (rst) begin
      beats.delete();
      rsps.delete();
      fifo_cnt_m = 0;
      vdue = 1'b0;
      rd_prev = 1'b0;
      err_at = INF;
    end else if (req_valid && req_ready) begin
      int n;
      beat_t b;
      n = req_burst ? 4 : 1;
      for (int i = 0; i < n; i++) begin
        b.wr   = req_wr;
        b.addr = 5'((int'(req_addr) & 16) + ((int'(req_addr) + i) % 8));
        b.data = 8'((int'(req_wdata) + i) % 256);
        b.acc  = cyc;
        b.last = (i == n - 1);
        beats.push_back(b);
      end
      fifo_cnt_m++;
    end
    cyc++;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      bit enb_exp;
      bit rd_now;
      beat_t b;
      rsp_t r;
      enb_exp = 1'b0;
      rd_now = 1'b0;
      if (vdue) begin
        enb_exp = 1'b1;
        rd_now = 1'b1;
        check_eq("verify_enb", 32'(mem_enb), 32'd1);
        check_eq("verify_rd", 32'(mem_rd), 32'd1);
        check_eq("verify_wr", 32'(mem_wr), 32'd0);
        check_eq("verify_raddr", 32'(mem_r_addr), 32'(vaddr));
        if (shadow[vaddr] != store_code(vdata) && cyc + 2 < err_at) err_at = cyc + 2;
        vdue = 1'b0;
      end else if (beats.size() > 0 && beats[0].acc <= cyc - 2) begin
        b = beats.pop_front();
        enb_exp = 1'b1;
        check_eq("beat_enb", 32'(mem_enb), 32'd1);
        check_eq("beat_wr", 32'(mem_wr), 32'(b.wr));
        check_eq("beat_rd", 32'(mem_rd), 32'(!b.wr));
        check_eq("beat_waddr", 32'(mem_w_addr), 32'(b.addr));
        check_eq("beat_raddr", 32'(mem_r_addr), 32'(b.addr));
        if (b.wr) begin
          check_eq("beat_wdata", 32'(mem_w_data), 32'(b.data));
          shadow[b.addr] = stored_word(b.addr, b.data);
          if (VERIFY_ON) begin
            vdue = 1'b1;
            vaddr = b.addr;
            vdata = b.data;
          end
        end else begin
          rd_now = 1'b1;
          r.due = cyc + 2;
          r.addr = b.addr;
          r.data = shadow[b.addr];
          rsps.push_back(r);
        end
        if (b.last) fifo_cnt_m--;
      end else begin
        check_eq("idle_enb", 32'(mem_enb), 32'd0);
      end
      check_eq("mem_burst", 32'(mem_burst), 32'd0);
      if (rsps.size() > 0 && rsps[0].due == cyc) begin
        r = rsps.pop_front();
        check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rsp_data", 32'(rsp_data), 32'(r.data));
        check_eq("rsp_addr", 32'(rsp_addr), 32'(r.addr));
      end else begin
        check_eq("rsp_quiet", 32'(rsp_valid), 32'd0);
      end
      check_eq("req_ready", 32'(req_ready), 32'(fifo_cnt_m < 4));
      check_eq("busy", 32'(busy), 32'(fifo_cnt_m > 0 || enb_exp || rd_prev));
      check_eq("verify_err", 32'(verify_err), 32'(cyc >= err_at));
      rd_prev = rd_now;
    end
    if (rsp_valid) begin
      last_rsp_data = rsp_data;
      last_rsp_addr = rsp_addr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit wr, input bit burst, input logic [4:0] addr,
                      input logic [7:0] data, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    req_valid = 1'b1;
    req_wr = wr;
    req_burst = burst;
    req_addr = addr;
    req_wdata = data;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waited++;
    end
    if (!ok) check_eq("send_timeout", 32'(ok), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!busy && beats.size() == 0 && rsps.size() == 0 && !vdue) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("drain", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int  w;
    bit  hit;
    for (int i = 0; i < 32; i++) begin
      env_mem[i] = 8'h00;
      shadow[i]  = 8'h00;
    end
    do_reset();
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_mem_enb", 32'(mem_enb), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
    check_eq("rst_mem_w_addr", 32'(mem_w_addr), 32'd0);
    check_eq("rst_mem_r_addr", 32'(mem_r_addr), 32'd0);
    check_eq("rst_mem_w_data", 32'(mem_w_data), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_rsp_addr", 32'(rsp_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_verify_err", 32'(verify_err), 32'd0);
    @(posedge clk);
    #1;

    // T1: write then read back
    send(1'b1, 1'b0, 5'h02, 8'h13, w);
    send(1'b0, 1'b0, 5'h02, 8'h00, w);
    wait_idle();
    check_eq("t1_rsp_data", 32'(last_rsp_data), 32'h13);
    check_eq("t1_rsp_addr", 32'(last_rsp_addr), 32'h02);

    // T2: wrapping burst write, then read it back as a burst
    send(1'b1, 1'b1, 5'h16, 8'hFE, w);
    send(1'b0, 1'b1, 5'h16, 8'h00, w);
    wait_idle();
    check_eq("t2_last_addr", 32'(last_rsp_addr), 32'h11);
    check_eq("t2_last_data", 32'(last_rsp_data), 32'h01);

    // T3: raw stored word is returned (0xF8 has 5 ones and is stored inverted)
    send(1'b1, 1'b0, 5'h05, 8'hF0, w);
    send(1'b0, 1'b0, 5'h05, 8'h00, w);
    wait_idle();
    check_eq("t3_f0", 32'(last_rsp_data), 32'hF0);
    send(1'b1, 1'b0, 5'h06, 8'hF8, w);
    send(1'b0, 1'b0, 5'h06, 8'h00, w);
    wait_idle();
    check_eq("t3_f8", 32'(last_rsp_data), 32'h07);

    // T4: five back-to-back burst reads overflow the 4-entry FIFO
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 1'b1, 5'(i * 3), 8'h00, w);
      if (i == 4) check_eq("t4_ready_drop", 32'(w > 0), 32'd1);
    end
    wait_idle();

    // T5: reset during beat 2 of a burst write
    send(1'b1, 1'b1, 5'h16, 8'h40, w);
    hit = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (mem_enb && mem_wr && mem_w_addr == 5'h10) begin
        hit = 1'b1;
        break;
      end
    end
    check_eq("t5_hit", 32'(hit), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_enb", 32'(mem_enb), 32'd0);
    check_eq("t5_ready", 32'(req_ready), 32'd1);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    wait_idle();

    // T6: stuck bit on write 0x13 @0x01
    flip_en = 1'b1;
    send(1'b1, 1'b0, 5'h01, 8'h13, w);
    wait_idle();
    flip_en = 1'b0;
    check_eq("t6_verify_err", 32'(verify_err), 32'(VERIFY_ON));
    for (int i = 0; i < 6; i++) begin
      send(1'($urandom_range(0, 1)), 1'b0, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), w);
    end
    wait_idle();
    check_eq("t6_sticky", 32'(verify_err), 32'(VERIFY_ON));
    do_reset();
    @(negedge clk);
    check_eq("t6_cleared", 32'(verify_err), 32'd0);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
